// File: rtl/ddc_edid_responder.sv
// DDC/EDID I2C target: serves a host-loaded 256-byte EDID
// image as a single-byte-offset EEPROM at DEV_ADDR.
module ddc_edid_responder #(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ddc_scl_i,
  input  logic       ddc_sda_i,
  output logic       ddc_sda_o,
  output logic       ddc_sda_t,
  input  logic       edid_we,
  input  logic [7:0] edid_waddr,
  input  logic [7:0] edid_wdata,
  output logic       busy,
  output logic [7:0] ptr
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK,
    WNACK, TX, TX_ACK, WAIT
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic [1:0] scl_s, sda_s;
  logic [3:0] scl_cnt, sda_cnt;
  logic       scl_f, sda_f, scl_q, sda_q;
  logic       scl_rise, scl_fall, start_c, stop_c;

  state_t     state, state_d;
  logic [2:0] bit_cnt, cnt_d;
  logic [7:0] sh, sh_d, sh_in;
  logic [7:0] ptr_q, ptr_d;
  logic       sda_t_q, sda_t_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;
  logic       ninth_q, ninth_d;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [7:0] mem [256];

  // synchronize pins and accept a new level only after FILTER_LEN equal samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s   <= 2'b11;
      sda_s   <= 2'b11;
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], ddc_scl_i};
      sda_s <= {sda_s[0], ddc_sda_i};
      if (scl_s[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CNT_MAX) begin
        scl_f   <= scl_s[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 4'd1;
      end
      if (sda_s[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CNT_MAX) begin
        sda_f   <= sda_s[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 4'd1;
      end
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign sh_in    = {sh[6:0], sda_f};

  // protocol state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      ptr_q   <= '0;
      sda_t_q <= 1'b1;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      ninth_q <= 1'b0;
    end else begin
      state   <= state_d;
      bit_cnt <= cnt_d;
      sh      <= sh_d;
      ptr_q   <= ptr_d;
      sda_t_q <= sda_t_d;
      busy_q  <= busy_d;
      rw_q    <= rw_d;
      ninth_q <= ninth_d;
    end
  end

  // next state: bus conditions first, then per-state bit handling
  always_comb begin
    state_d = state;
    cnt_d   = bit_cnt;
    sh_d    = sh;
    ptr_d   = ptr_q;
    sda_t_d = sda_t_q;
    busy_d  = busy_q;
    rw_d    = rw_q;
    ninth_d = ninth_q;
    rd_en   = 1'b0;
    if (stop_c) begin
      state_d = IDLE;
      sda_t_d = 1'b1;
      busy_d  = 1'b0;
    end else if (start_c) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_t_d = 1'b1;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (sh_in[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sh_in[0];
              ninth_d = 1'b0;
              rd_en   = sh_in[0];
            end else begin
              state_d = WAIT;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK, OFFSET_ACK: begin
          if (scl_rise) begin
            ninth_d = 1'b1;
          end else if (scl_fall) begin
            if (!ninth_q) begin
              sda_t_d = 1'b0;
            end else if (state == ADDR_ACK && rw_q) begin
              state_d = TX;
              cnt_d   = 3'd7;
              sda_t_d = rd_data[7];
            end else begin
              sda_t_d = 1'b1;
              cnt_d   = '0;
              state_d = (state == ADDR_ACK) ? OFFSET : WNACK;
            end
          end
        end
        OFFSET: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_d = OFFSET_ACK;
            ninth_d = 1'b0;
            ptr_d   = sh_in;
            rd_en   = 1'b1;
          end
        end
        WNACK: if (scl_rise) begin
          cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = WAIT;
        end
        TX: begin
          if (scl_rise) begin
            cnt_d = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              state_d = TX_ACK;
              ninth_d = 1'b0;
              ptr_d   = ptr_q + 8'd1;
              rd_en   = 1'b1;
            end
          end else if (scl_fall) begin
            sda_t_d = rd_data[bit_cnt];
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_f) state_d = WAIT;
            else ninth_d = 1'b1;
          end else if (scl_fall) begin
            if (!ninth_q) begin
              sda_t_d = 1'b1;
            end else begin
              state_d = TX;
              cnt_d   = 3'd7;
              sda_t_d = rd_data[7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // EDID RAM: host write port, read-first prefetch port
  always_ff @(posedge clk) begin
    if (edid_we) mem[edid_waddr] <= edid_wdata;
    if (rd_en) rd_data <= mem[ptr_d];
  end

  assign ddc_sda_o = 1'b0;
  assign ddc_sda_t = sda_t_q;
  assign busy      = busy_q;
  assign ptr       = ptr_q;

endmodule
